lane_stripe_skp: RTL and testbench

// Gen1/Gen2 transmit lane-management stage directly downstream of the framing stage.
// - Consumes the framed 32-bit AXIS byte stream (STP/SDP/END already inserted, per-byte K flags in tuser).
// - Stripes each beat one byte per lane across a x4 link.
// - Schedules SKP ordered sets at packet boundaries and fills gaps with logical idle.
// - Drives the per-lane 8b/10b encoder inputs.

---
 rtl/lane_stripe_skp.sv | 178 +++++++++++++++++
 tb/tb_lane_stripe_skp.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_stripe_skp.sv
// Transmit lane-management stage: stripes framed 32-bit beats across a x4
// link, inserts SKP ordered sets at packet boundaries and fills gaps with
// logical idle ahead of the per-lane 8b/10b encoders.
module lane_stripe_skp #(
  parameter int unsigned SKP_INTERVAL = 1180,
  parameter logic [7:0]  COM_SYM      = 8'hBC,
  parameter logic [7:0]  SKP_SYM      = 8'h1C
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        link_en_i,
  input  logic [31:0] s_axis_tdata,
  input  logic [3:0]  s_axis_tkeep,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  input  logic [3:0]  s_axis_tuser,
  output logic        s_axis_tready,
  output logic [31:0] lane_data_o,
  output logic [3:0]  lane_datak_o,
  output logic        lane_valid_o,
  input  logic        lane_ready_i,
  output logic        skp_sent_o
);

  localparam int unsigned LANES = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned CW    = 12;
  localparam logic [CW-1:0] CNT_LAST = CW'(SKP_INTERVAL - 1);

  typedef enum logic [2:0] {
    ST_DATA,
    ST_SKP_COM,
    ST_SKP_1,
    ST_SKP_2,
    ST_SKP_3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   skp_cnt_q, skp_cnt_d;
  logic            skp_pend_q, skp_pend_d;
  logic            in_pkt_q, in_pkt_d;
  logic [DW-1:0]   data_d;
  logic [LANES-1:0] datak_d;
  logic            valid_d;
  logic            sent_d;

  logic            load;
  logic            accept;
  logic            skp_start;
  logic            com_out;
  logic [DW-1:0]   beat_data;
  logic [LANES-1:0] beat_k;

  // Output register may load when the encoder takes the current symbols or holds none.
  assign load = lane_ready_i || !lane_valid_o;

  // Upstream is held off during SKP, during a due SKP outside a packet, and on stall.
  assign s_axis_tready = link_en_i && lane_ready_i && (state_q == ST_DATA) &&
                         !(skp_pend_q && !in_pkt_q);
  assign accept        = s_axis_tvalid && s_axis_tready;

  // A due SKP may only start between packets and when the output can advance.
  assign skp_start = link_en_i && (state_q == ST_DATA) && skp_pend_q &&
                     !in_pkt_q && lane_ready_i;

  // The COM of a SKP ordered set is currently presented on every lane.
  assign com_out = lane_valid_o && (lane_datak_o == 4'hF) &&
                   (lane_data_o == {LANES{COM_SYM}});

  // Stripe one byte per lane; dropped bytes become logical idle data symbols.
  always_comb begin
    beat_data = '0;
    beat_k    = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (s_axis_tkeep[i]) begin
        beat_data[8*i +: 8] = s_axis_tdata[8*i +: 8];
        beat_k[i]           = s_axis_tuser[i];
      end
    end
  end

  // Next-state, SKP scheduling and next output symbols.
  always_comb begin
    state_d    = state_q;
    skp_cnt_d  = skp_cnt_q;
    skp_pend_d = skp_pend_q;
    in_pkt_d   = in_pkt_q;
    data_d     = lane_data_o;
    datak_d    = lane_datak_o;
    valid_d    = lane_valid_o;
    sent_d     = com_out && lane_ready_i;

    if (!link_en_i) begin
      state_d    = ST_DATA;
      skp_cnt_d  = '0;
      skp_pend_d = 1'b0;
      in_pkt_d   = 1'b0;
      data_d     = '0;
      datak_d    = '0;
      valid_d    = 1'b0;
      sent_d     = 1'b0;
    end else begin
      case (state_q)
        ST_DATA: begin
          if (load) begin
            valid_d = 1'b1;
            data_d  = '0;
            datak_d = '0;
            if (skp_start) begin
              state_d    = ST_SKP_COM;
              skp_cnt_d  = '0;
              skp_pend_d = 1'b0;
            end else begin
              if (accept) begin
                data_d   = beat_data;
                datak_d  = beat_k;
                in_pkt_d = !s_axis_tlast;
              end
              if (!skp_pend_q) begin
                skp_cnt_d = CW'(skp_cnt_q + CW'(1));
                if (CW'(skp_cnt_q + CW'(1)) == CNT_LAST) begin
                  skp_pend_d = 1'b1;
                end
              end
            end
          end
        end
        ST_SKP_COM: begin
          if (lane_ready_i) begin
            data_d  = {LANES{COM_SYM}};
            datak_d = 4'hF;
            valid_d = 1'b1;
            state_d = ST_SKP_1;
          end
        end
        ST_SKP_1, ST_SKP_2, ST_SKP_3: begin
          if (lane_ready_i) begin
            data_d  = {LANES{SKP_SYM}};
            datak_d = 4'hF;
            valid_d = 1'b1;
            case (state_q)
              ST_SKP_1: state_d = ST_SKP_2;
              ST_SKP_2: state_d = ST_SKP_3;
              default:  state_d = ST_DATA;
            endcase
          end
        end
        default: begin
          state_d = ST_DATA;
        end
      endcase
    end
  end

  // State, scheduling and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_DATA;
      skp_cnt_q    <= '0;
      skp_pend_q   <= 1'b0;
      in_pkt_q     <= 1'b0;
      lane_data_o  <= '0;
      lane_datak_o <= '0;
      lane_valid_o <= 1'b0;
      skp_sent_o   <= 1'b0;
    end else begin
      state_q      <= state_d;
      skp_cnt_q    <= skp_cnt_d;
      skp_pend_q   <= skp_pend_d;
      in_pkt_q     <= in_pkt_d;
      lane_data_o  <= data_d;
      lane_datak_o <= datak_d;
      lane_valid_o <= valid_d;
      skp_sent_o   <= sent_d;
    end
  end

endmodule

// File: tb/tb_lane_stripe_skp.sv
// Bench for lane_stripe_skp: table-driven striping vectors plus directed
// SKP, back-pressure, link-drop and async-reset sequences, checked through
// a queue of expected lane outputs.
module tb_lane_stripe_skp;

  localparam int unsigned INTV = 8;
  localparam logic [7:0]  COM  = 8'hBC;
  localparam logic [7:0]  SKP  = 8'h1C;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        link_en_i;
  logic [31:0] s_axis_tdata;
  logic [3:0]  s_axis_tkeep;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic [3:0]  s_axis_tuser;
  logic        s_axis_tready;
  logic [31:0] lane_data_o;
  logic [3:0]  lane_datak_o;
  logic        lane_valid_o;
  logic        lane_ready_i;
  logic        skp_sent_o;

  lane_stripe_skp #(
    .SKP_INTERVAL(INTV),
    .COM_SYM     (COM),
    .SKP_SYM     (SKP)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .link_en_i    (link_en_i),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tkeep (s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tuser (s_axis_tuser),
    .s_axis_tready(s_axis_tready),
    .lane_data_o  (lane_data_o),
    .lane_datak_o (lane_datak_o),
    .lane_valid_o (lane_valid_o),
    .lane_ready_i (lane_ready_i),
    .skp_sent_o   (skp_sent_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  k;
    logic        valid;
    logic        sent;
  } out_t;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  keep;
    logic [3:0]  user;
    logic        last;
    logic [31:0] ed;
    logic [3:0]  ek;
  } vec_t;

  out_t exp_q[$];
  vec_t vecs[7];
  vec_t idle_v;

  int checks = 0;
  int passes = 0;

  // reference model of the scheduler
  int unsigned m_st;
  int unsigned m_cnt;
  bit          m_pend;
  bit          m_inpkt;
  out_t        m_out;

  // observations for the SKP-boundary sequence
  bit pkt_open;
  int com_mid;
  int sent_seen;

  function automatic vec_t mk(input logic [31:0] d, input logic [3:0] keep,
                              input logic [3:0] user, input logic last,
                              input logic [31:0] ed, input logic [3:0] ek);
    vec_t v;
    v.d = d; v.keep = keep; v.user = user; v.last = last; v.ed = ed; v.ek = ek;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
  endtask

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_pend = 0; m_inpkt = 0; m_out = '0;
    exp_q.delete();
  endtask

  // One clock: drive inputs, check tready, predict outputs, compare after the edge.
  task automatic cycle(input bit en, input bit rdy, input bit vld, input vec_t v, output bit acc);
    bit   exp_rdy;
    out_t nxt;
    out_t e;
    link_en_i     = en;
    lane_ready_i  = rdy;
    s_axis_tvalid = vld;
    s_axis_tdata  = v.d;
    s_axis_tkeep  = v.keep;
    s_axis_tuser  = v.user;
    s_axis_tlast  = v.last;
    #1;
    exp_rdy = en && rdy && (m_st == 0) && !(m_pend && !m_inpkt);
    chk("tready", 32'(s_axis_tready), 32'(exp_rdy));
    acc = vld && exp_rdy;
    nxt = m_out;
    nxt.sent = m_out.valid && rdy && (m_out.data == {4{COM}}) && (m_out.k == 4'hF);
    if (!en) begin
      m_st = 0; m_cnt = 0; m_pend = 0; m_inpkt = 0;
      nxt = '0;
    end else if (m_st == 0) begin
      if (rdy || !m_out.valid) begin
        nxt.valid = 1'b1;
        nxt.data  = '0;
        nxt.k     = '0;
        if (m_pend && !m_inpkt && rdy) begin
          m_st = 1; m_cnt = 0; m_pend = 0;
        end else begin
          if (acc) begin
            nxt.data = v.ed;
            nxt.k    = v.ek;
            m_inpkt  = !v.last;
          end
          if (!m_pend) begin
            m_cnt++;
            if (m_cnt == INTV - 1) m_pend = 1;
          end
        end
      end
    end else if (rdy) begin
      nxt.data  = (m_st == 1) ? {4{COM}} : {4{SKP}};
      nxt.k     = 4'hF;
      nxt.valid = 1'b1;
      m_st      = (m_st == 4) ? 0 : m_st + 1;
    end
    m_out = nxt;
    exp_q.push_back(nxt);
    @(posedge clk_i);
    #1;
    e = exp_q.pop_front();
    chk("lane_data",  lane_data_o,         e.data);
    chk("lane_datak", 32'(lane_datak_o),   32'(e.k));
    chk("lane_valid", 32'(lane_valid_o),   32'(e.valid));
    chk("skp_sent",   32'(skp_sent_o),     32'(e.sent));
    if (skp_sent_o) sent_seen++;
    if (pkt_open && lane_valid_o && lane_datak_o == 4'hF) com_mid++;
  endtask

  // Offer a beat until the model says it is taken; a long wait is a failure.
  task automatic send(input vec_t v);
    bit acc;
    int n;
    acc = 0;
    n = 0;
    while (!acc && n < 64) begin
      cycle(1'b1, 1'b1, 1'b1, v, acc);
      n++;
    end
    if (!acc) begin
      checks++;
      $display("FAIL send_timeout: beat %h not accepted after %0d cycles", v.d, n);
    end
  endtask

  task automatic idle(input int n, input bit rdy);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b1, rdy, 1'b0, idle_v, acc);
  endtask

  // Run idle cycles until the model reaches the requested state.
  task automatic wait_state(input int unsigned st, input string name);
    bit acc;
    int n;
    n = 0;
    while (m_st != st && n < 40) begin
      cycle(1'b1, 1'b1, 1'b0, idle_v, acc);
      n++;
    end
    if (m_st != st) begin
      checks++;
      $display("FAIL %s_timeout: state %0d not reached", name, st);
    end
  endtask

  initial begin
    bit acc;
    idle_v = mk(32'h0, 4'h0, 4'h0, 1'b0, 32'h0, 4'h0);
    vecs[0] = mk(32'h1122_33FB, 4'hF,    4'b0001, 1'b0, 32'h1122_33FB, 4'b0001);
    vecs[1] = mk(32'hDEAD_BEEF, 4'hF,    4'b0000, 1'b0, 32'hDEAD_BEEF, 4'b0000);
    vecs[2] = mk(32'hAABB_CCDD, 4'b0111, 4'b0100, 1'b1, 32'h00BB_CCDD, 4'b0100);
    vecs[3] = mk(32'h5A5A_5A5A, 4'b0000, 4'b1111, 1'b1, 32'h0000_0000, 4'b0000);
    vecs[4] = mk(32'h3344_5566, 4'b1010, 4'b1111, 1'b1, 32'h3300_5500, 4'b1010);
    vecs[5] = mk(32'h0102_0304, 4'b0101, 4'b0011, 1'b0, 32'h0002_0004, 4'b0001);
    vecs[6] = mk(32'hCAFE_F00D, 4'hF,    4'b1000, 1'b1, 32'hCAFE_F00D, 4'b1000);

    pkt_open = 0; com_mid = 0; sent_seen = 0;
    rst_ni = 1'b0; link_en_i = 1'b0; lane_ready_i = 1'b1;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0;
    s_axis_tuser = '0; s_axis_tlast = 1'b0;
    model_reset();

    // reset values
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_data",  lane_data_o,        32'h0);
    chk("rst_datak", 32'(lane_datak_o),  32'h0);
    chk("rst_valid", 32'(lane_valid_o),  32'h0);
    chk("rst_sent",  32'(skp_sent_o),    32'h0);
    rst_ni = 1'b1;

    // idle after reset, then striping vectors
    idle(2, 1'b1);
    foreach (vecs[i]) send(vecs[i]);
    idle(3, 1'b1);

    // link drop mid-packet, then re-enable and idle to count 2
    send(vecs[0]);
    cycle(1'b0, 1'b1, 1'b1, vecs[1], acc);
    cycle(1'b1, 1'b1, 1'b0, idle_v, acc);
    cycle(1'b1, 1'b1, 1'b0, idle_v, acc);

    // 20-beat packet straddling a due SKP
    sent_seen = 0;
    com_mid   = 0;
    pkt_open  = 1;
    for (int i = 0; i < 20; i++) begin
      send(mk(32'h1000_0000 + 32'(i), 4'hF, 4'h0, (i == 19), 32'h1000_0000 + 32'(i), 4'h0));
    end
    pkt_open = 0;
    chk("com_mid_pkt", 32'(com_mid), 32'd0);
    idle(8, 1'b1);
    chk("skp_sent_count", 32'(sent_seen), 32'd1);

    // back-pressure while the COM is presented
    wait_state(2, "skp1");
    idle(3, 1'b0);
    idle(6, 1'b1);

    // async reset in the middle of a SKP ordered set
    wait_state(3, "skp2");
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_data",  lane_data_o,        32'h0);
    chk("arst_datak", 32'(lane_datak_o),  32'h0);
    chk("arst_valid", 32'(lane_valid_o),  32'h0);
    chk("arst_sent",  32'(skp_sent_o),    32'h0);
    model_reset();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    idle(3, 1'b1);
    send(vecs[6]);
    idle(2, 1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
